// File: rtl/shiftreg_4094_sequencer.sv
// rtl/shiftreg_4094_sequencer.sv - serial loader/readback sequencer for a daisy-chained 4094 chain
module shiftreg_4094_sequencer #(
  parameter int N_BITS        = 16,
  parameter int CLK_DIV       = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_host,
  input  logic [N_BITS-1:0] data_host,
  output logic              ack_host,
  input  logic              req_safe,
  input  logic [N_BITS-1:0] data_safe,
  output logic              ack_safe,
  input  logic              oe_clear,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] readback,
  output logic              readback_valid,
  output logic              mismatch,
  output logic              sr_clk,
  output logic              sr_data,
  output logic              sr_strobe,
  output logic              sr_oe,
  input  logic              sr_miso
);

  localparam int CW      = $clog2(N_BITS);
  localparam int DIV_MAX = (CLK_DIV > STROBE_CYCLES) ? CLK_DIV : STROBE_CYCLES;
  localparam int DW      = $clog2(DIV_MAX + 1);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] STR_END = DW'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, STROBE} state_t;

  state_t            state, state_nxt;
  logic              grant;
  logic              grant_safe;
  logic [DW-1:0]     div_cnt;
  logic [CW-1:0]     bit_cnt;
  logic [N_BITS-1:0] tx_word;
  logic [N_BITS-1:0] capture;
  logic [N_BITS-1:0] committed;
  logic              have_committed;
  logic              sr_clk_q;
  logic              sr_strobe_q;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (req_safe || req_host) begin
          grant     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:     state_nxt = SHIFT_LO;
      SHIFT_LO: if (div_cnt == DIV_END) state_nxt = SHIFT_HI;
      SHIFT_HI: if (div_cnt == DIV_END) state_nxt = (bit_cnt == '0) ? STROBE : SHIFT_LO;
      STROBE:   if (div_cnt == STR_END) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // sr_clk and sr_strobe come straight from flops so the chain never sees decode glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      grant_safe     <= 1'b0;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      tx_word        <= '0;
      capture        <= '0;
      committed      <= '0;
      have_committed <= 1'b0;
      done           <= 1'b0;
      readback       <= '0;
      readback_valid <= 1'b0;
      mismatch       <= 1'b0;
      sr_oe          <= 1'b0;
      sr_clk_q       <= 1'b0;
      sr_strobe_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= (state_nxt != state) ? '0 : div_cnt + 1'b1;
      sr_clk_q    <= (state_nxt == SHIFT_HI);
      sr_strobe_q <= (state_nxt == STROBE);
      done        <= (state == STROBE) && (state_nxt == IDLE);

      if (grant) begin
        tx_word    <= req_safe ? data_safe : data_host;
        grant_safe <= req_safe;
        bit_cnt    <= CW'(N_BITS - 1);
      end

      if (state == SHIFT_HI && div_cnt == '0)
        capture <= {capture[N_BITS-2:0], sr_miso};
      if (state == SHIFT_HI && div_cnt == DIV_END && bit_cnt != '0)
        bit_cnt <= bit_cnt - 1'b1;

      // tx_word may be reloaded by a grant in this same cycle; committed takes the old word
      if (done) begin
        readback       <= capture;
        readback_valid <= have_committed;
        mismatch       <= have_committed && (capture != committed);
        committed      <= tx_word;
        have_committed <= 1'b1;
      end

      if (oe_clear)
        sr_oe <= 1'b0;
      else if (done)
        sr_oe <= 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign ack_safe  = (state == LOAD) && grant_safe;
  assign ack_host  = (state == LOAD) && !grant_safe;
  assign sr_clk    = sr_clk_q;
  assign sr_strobe = sr_strobe_q;
  assign sr_data   = (state == LOAD || state == SHIFT_LO || state == SHIFT_HI) ? tx_word[bit_cnt] : 1'b0;

endmodule
